// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
//   Shared types and constants for the CAN receive frame decoder.
//   - can_state_e      : decoder FSM state (also exported for debug)
//   - *_W              : field widths used on the decoder ports
//   - *_LEN            : bit counts of fixed-length frame fields
//   - STUFF_LIMIT      : run length after which a stuff bit follows
//   - IDLE_RECOVERY    : recessive samples needed to leave ERROR
//   - in_stuff_region  : states in which bit destuffing is active
// ---------------------------------------------------------------------------
package can_pkg;

   typedef enum logic [4:0] {
      IDLE,
      ID_A,
      RTR_SRR,
      IDE,
      ID_B,
      RTR,
      R1,
      R0,
      DLC,
      DATA,
      CRC,
      CRC_DELIM,
      ACK_SLOT,
      ACK_DELIM,
      EOF,
      INTERMISSION,
      ERROR
   } can_state_e;

   localparam int ID_A_W = 11;
   localparam int ID_B_W = 18;
   localparam int DLC_W  = 4;
   localparam int DATA_W = 64;
   localparam int CRC_W  = 15;

   localparam logic [6:0] ID_A_LEN         = 7'd11;
   localparam logic [6:0] ID_B_LEN         = 7'd18;
   localparam logic [6:0] DLC_LEN          = 7'd4;
   localparam logic [6:0] CRC_LEN          = 7'd15;
   localparam logic [6:0] EOF_LEN          = 7'd7;
   localparam logic [6:0] INTERMISSION_LEN = 7'd3;

   localparam logic [2:0] STUFF_LIMIT   = 3'd5;
   localparam logic [3:0] IDLE_RECOVERY = 4'd11;

   // SOF is handled separately by the decoder (it is seen while still IDLE).
   function automatic logic in_stuff_region(input can_state_e s);
      return (s inside {ID_A, RTR_SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC});
   endfunction

endpackage

// File: rtl/can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// can_bit_destuffer
//   Tracks the run of equal bus bits and classifies each sampled bit.
//   Ports:
//     clock, reset  : clock, asynchronous active-high reset
//     rx_bit        : sampled bus level
//     valid         : rx_bit is a new sample this clock
//     enable        : destuffing active for this sample
//     clear         : restart the run count (used outside the stuffed region)
//     data_valid    : sample is a payload bit (not a stuff bit)
//     is_stuff      : sample is a stuff bit and must be discarded
//     stuff_error   : stuff bit has the same level as the preceding run
// ---------------------------------------------------------------------------
module can_bit_destuffer
   import can_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic rx_bit,
   input  logic valid,
   input  logic enable,
   input  logic clear,
   output logic data_valid,
   output logic is_stuff,
   output logic stuff_error
);

   logic       last_bit;
   logic [2:0] run_cnt;
   logic       stuff_slot;

   assign stuff_slot  = (run_cnt == STUFF_LIMIT);
   assign is_stuff    = valid & enable & stuff_slot;
   assign stuff_error = is_stuff & (rx_bit == last_bit);
   assign data_valid  = valid & enable & ~stuff_slot;

   // A stuff bit opens the next run, so it restarts the count at 1.
   // run_cnt == 0 means "no history": the next bit always starts a run.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_bit <= 1'b1;
         run_cnt  <= '0;
      end else if (clear) begin
         run_cnt  <= '0;
      end else if (valid && enable) begin
         if (stuff_slot || (run_cnt == 3'd0) || (rx_bit != last_bit))
            run_cnt <= 3'd1;
         else
            run_cnt <= run_cnt + 3'd1;
         last_bit <= rx_bit;
      end
   end

endmodule

// File: rtl/can_frame_decoder.sv
// ---------------------------------------------------------------------------
// can_frame_decoder
//   Receive-side CAN 2.0A/2.0B frame decoder. Walks the frame one sampled bit
//   at a time (rising edge of sample_point), strips stuff bits from SOF to
//   the last CRC bit and publishes every field as a registered output.
//   Ports:
//     clock, reset        : clock, asynchronous active-high reset
//     rx_bit              : bus level (0 dominant, 1 recessive)
//     sample_point        : rx_bit is taken on its 0->1 transition
//     error_in            : external abort, checked every clock
//     error_out           : stuff/form error detected by this decoder
//     field_*             : decoded frame fields, held until the next SOF
//     state_dbg           : current FSM state
// ---------------------------------------------------------------------------
module can_frame_decoder
   import can_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              rx_bit,
   input  logic              sample_point,
   input  logic              error_in,
   output logic              error_out,
   output logic              field_start_of_frame,
   output logic [ID_A_W-1:0] field_id_a,
   output logic              field_ide,
   output logic              field_rtr,
   output logic              field_srr,
   output logic              field_reserved1,
   output logic              field_reserved0,
   output logic [ID_B_W-1:0] field_id_b,
   output logic [DLC_W-1:0]  field_dlc,
   output logic [DATA_W-1:0] field_data,
   output logic [CRC_W-1:0]  field_crc,
   output logic              field_crc_delimiter,
   output logic              field_ack_slot,
   output can_state_e        state_dbg
);

   can_state_e state;
   logic       sp_q;
   logic       sample;
   logic       sof;
   logic       destuff_en;
   logic       form_error;
   logic [6:0] bit_cnt;
   logic [6:0] data_len;
   logic [3:0] rec_cnt;
   logic [3:0] dlc_next;
   logic [6:0] data_bits;
   logic       ds_data_valid;
   logic       ds_is_stuff;
   logic       ds_stuff_error;

   assign state_dbg = state;
   assign sample    = sample_point & ~sp_q;
   assign sof       = sample & ~error_in & ~rx_bit & (state == IDLE);
   assign destuff_en = sof | in_stuff_region(state);

   // Delimiters and EOF are fixed recessive; a dominant level there is a form error.
   assign form_error = sample & ~error_in & ~rx_bit &
                       ((state == CRC_DELIM) || (state == ACK_DELIM) || (state == EOF));

   // DLC values above 8 still mean 8 data bytes.
   assign dlc_next  = {field_dlc[2:0], rx_bit};
   assign data_bits = dlc_next[3] ? 7'd64 : {1'b0, dlc_next[2:0], 3'b000};

   can_bit_destuffer u_destuffer (
      .clock       (clock),
      .reset       (reset),
      .rx_bit      (rx_bit),
      .valid       (sample & ~error_in),
      .enable      (destuff_en),
      .clear       (error_in | ~destuff_en),
      .data_valid  (ds_data_valid),
      .is_stuff    (ds_is_stuff),
      .stuff_error (ds_stuff_error)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp_q                 <= 1'b0;
         state                <= IDLE;
         bit_cnt              <= '0;
         data_len             <= '0;
         rec_cnt              <= '0;
         error_out            <= 1'b0;
         field_start_of_frame <= 1'b0;
         field_id_a           <= '0;
         field_ide            <= 1'b0;
         field_rtr            <= 1'b0;
         field_srr            <= 1'b0;
         field_reserved1      <= 1'b0;
         field_reserved0      <= 1'b0;
         field_id_b           <= '0;
         field_dlc            <= '0;
         field_data           <= '0;
         field_crc            <= '0;
         field_crc_delimiter  <= 1'b0;
         field_ack_slot       <= 1'b0;
      end else begin
         sp_q <= sample_point;
         if (error_in) begin
            // External abort: error_out is left as it is.
            state   <= ERROR;
            rec_cnt <= '0;
         end else if (ds_stuff_error || form_error) begin
            state     <= ERROR;
            rec_cnt   <= '0;
            error_out <= 1'b1;
         end else if (sample && !ds_is_stuff) begin
            case (state)
               IDLE: begin
                  if (!rx_bit) begin
                     field_start_of_frame <= rx_bit;
                     field_id_a           <= '0;
                     field_ide            <= 1'b0;
                     field_rtr            <= 1'b0;
                     field_srr            <= 1'b0;
                     field_reserved1      <= 1'b0;
                     field_reserved0      <= 1'b0;
                     field_id_b           <= '0;
                     field_dlc            <= '0;
                     field_data           <= '0;
                     field_crc            <= '0;
                     field_crc_delimiter  <= 1'b0;
                     field_ack_slot       <= 1'b0;
                     bit_cnt              <= '0;
                     state                <= ID_A;
                  end
               end
               ID_A: begin
                  field_id_a <= {field_id_a[ID_A_W-2:0], rx_bit};
                  if (bit_cnt == ID_A_LEN - 7'd1) begin
                     bit_cnt <= '0;
                     state   <= RTR_SRR;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               // The bit is parked in field_rtr; IDE decides whether it was SRR.
               RTR_SRR: begin
                  field_rtr <= rx_bit;
                  state     <= IDE;
               end
               IDE: begin
                  field_ide <= rx_bit;
                  if (rx_bit) begin
                     field_srr <= field_rtr;
                     field_rtr <= 1'b0;
                     state     <= ID_B;
                  end else begin
                     state     <= R0;
                  end
               end
               ID_B: begin
                  field_id_b <= {field_id_b[ID_B_W-2:0], rx_bit};
                  if (bit_cnt == ID_B_LEN - 7'd1) begin
                     bit_cnt <= '0;
                     state   <= RTR;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               RTR: begin
                  field_rtr <= rx_bit;
                  state     <= R1;
               end
               R1: begin
                  field_reserved1 <= rx_bit;
                  state           <= R0;
               end
               R0: begin
                  field_reserved0 <= rx_bit;
                  bit_cnt         <= '0;
                  state           <= DLC;
               end
               DLC: begin
                  field_dlc <= dlc_next;
                  if (bit_cnt == DLC_LEN - 7'd1) begin
                     bit_cnt  <= '0;
                     data_len <= data_bits;
                     if (field_rtr || (dlc_next == 4'd0))
                        state <= CRC;
                     else
                        state <= DATA;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               DATA: begin
                  field_data <= {field_data[DATA_W-2:0], rx_bit};
                  if (bit_cnt == data_len - 7'd1) begin
                     bit_cnt <= '0;
                     state   <= CRC;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               CRC: begin
                  field_crc <= {field_crc[CRC_W-2:0], rx_bit};
                  if (bit_cnt == CRC_LEN - 7'd1) begin
                     bit_cnt <= '0;
                     state   <= CRC_DELIM;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               CRC_DELIM: begin
                  field_crc_delimiter <= rx_bit;
                  state               <= ACK_SLOT;
               end
               ACK_SLOT: begin
                  field_ack_slot <= rx_bit;
                  state          <= ACK_DELIM;
               end
               ACK_DELIM: begin
                  bit_cnt <= '0;
                  state   <= EOF;
               end
               EOF: begin
                  if (bit_cnt == EOF_LEN - 7'd1) begin
                     bit_cnt <= '0;
                     state   <= INTERMISSION;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               INTERMISSION: begin
                  if (bit_cnt == INTERMISSION_LEN - 7'd1) begin
                     bit_cnt <= '0;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               ERROR: begin
                  // Leave only after an unbroken run of recessive samples.
                  if (!rx_bit) begin
                     rec_cnt <= '0;
                  end else if (rec_cnt == IDLE_RECOVERY - 4'd1) begin
                     rec_cnt   <= '0;
                     error_out <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     rec_cnt <= rec_cnt + 4'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_can_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_can_frame_decoder
//   Directed bench for can_frame_decoder. Frames are either given as a raw
//   bus vector or assembled and bit-stuffed here from field values; every
//   expected field value is written out by hand in the test tasks.
// ---------------------------------------------------------------------------
module tb_can_frame_decoder;
   import can_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clock = 1'b0;
   logic        reset;
   logic        rx_bit;
   logic        sample_point;
   logic        error_in;
   logic        error_out;
   logic        field_start_of_frame;
   logic [10:0] field_id_a;
   logic        field_ide;
   logic        field_rtr;
   logic        field_srr;
   logic        field_reserved1;
   logic        field_reserved0;
   logic [17:0] field_id_b;
   logic [3:0]  field_dlc;
   logic [63:0] field_data;
   logic [14:0] field_crc;
   logic        field_crc_delimiter;
   logic        field_ack_slot;
   can_state_e  state_dbg;

   always #5 clock = ~clock;

   can_frame_decoder dut (
      .clock                (clock),
      .reset                (reset),
      .rx_bit               (rx_bit),
      .sample_point         (sample_point),
      .error_in             (error_in),
      .error_out            (error_out),
      .field_start_of_frame (field_start_of_frame),
      .field_id_a           (field_id_a),
      .field_ide            (field_ide),
      .field_rtr            (field_rtr),
      .field_srr            (field_srr),
      .field_reserved1      (field_reserved1),
      .field_reserved0      (field_reserved0),
      .field_id_b           (field_id_b),
      .field_dlc            (field_dlc),
      .field_data           (field_data),
      .field_crc            (field_crc),
      .field_crc_delimiter  (field_crc_delimiter),
      .field_ack_slot       (field_ack_slot),
      .state_dbg            (state_dbg)
   );

   logic [119:0] fields;
   assign fields = {field_start_of_frame, field_id_a, field_ide, field_rtr, field_srr,
                    field_reserved1, field_reserved0, field_id_b, field_dlc, field_data,
                    field_crc, field_crc_delimiter, field_ack_slot};

   int   n_checks = 0;
   int   n_fail   = 0;
   logic tx_q[$];
   int   region_len;
   int   crc_tx_idx;
   logic err_seen;
   logic err_at_sample;

   function automatic logic [119:0] exp_fields(input logic [10:0] id_a, input logic ide,
      input logic rtr, input logic srr, input logic r1, input logic r0,
      input logic [17:0] id_b, input logic [3:0] dlc, input logic [63:0] data_v,
      input logic [14:0] crc_v, input logic delim, input logic ack);
      return {1'b0, id_a, ide, rtr, srr, r1, r0, id_b, dlc, data_v, crc_v, delim, ack};
   endfunction

   // ---------------- driver tasks ----------------
   // One bus bit = 6 clocks with sample_point high for one clock.
   task automatic send_bit(input logic b);
      @(posedge clock); #1;
      rx_bit       = b;
      sample_point = 1'b1;
      @(posedge clock); #1;
      sample_point  = 1'b0;
      err_at_sample = error_out;
      if (error_out) err_seen = 1'b1;
      repeat (4) @(posedge clock);
      #1;
   endtask

   task automatic send_range(input int first, input int last_excl);
      for (int i = first; i < last_excl; i++) send_bit(tx_q[i]);
   endtask

   task automatic send_ones(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   // Assembles a frame and stuffs it from SOF through the last CRC bit.
   task automatic build_frame(input logic ide, input logic [10:0] id_a, input logic [17:0] id_b,
                              input logic rtr, input logic [3:0] dlc, input logic [63:0] data_v,
                              input logic [14:0] crc_v);
      logic raw[$];
      int   nbits;
      int   crc_raw_idx;
      int   run;
      logic last;
      raw.delete();
      tx_q.delete();
      raw.push_back(1'b0);
      for (int i = 10; i >= 0; i--) raw.push_back(id_a[i]);
      if (ide) begin
         raw.push_back(1'b1);
         raw.push_back(1'b1);
         for (int i = 17; i >= 0; i--) raw.push_back(id_b[i]);
         raw.push_back(rtr);
         raw.push_back(1'b0);
      end else begin
         raw.push_back(rtr);
         raw.push_back(1'b0);
      end
      raw.push_back(1'b0);
      for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
      nbits = rtr ? 0 : ((dlc > 4'd8) ? 64 : 8 * int'(dlc));
      for (int i = nbits - 1; i >= 0; i--) raw.push_back(data_v[i]);
      crc_raw_idx = raw.size();
      for (int i = 14; i >= 0; i--) raw.push_back(crc_v[i]);
      run  = 0;
      last = 1'b1;
      crc_tx_idx = 0;
      for (int i = 0; i < raw.size(); i++) begin
         if (run == 5) begin
            tx_q.push_back(~last);
            last = ~last;
            run  = 1;
         end
         if (i == crc_raw_idx) crc_tx_idx = tx_q.size();
         if (raw[i] == last) run++;
         else begin
            run  = 1;
            last = raw[i];
         end
         tx_q.push_back(raw[i]);
      end
      region_len = tx_q.size();
      tx_q.push_back(1'b1);                    // CRC delimiter
      tx_q.push_back(1'b0);                    // ACK slot driven dominant
      tx_q.push_back(1'b1);                    // ACK delimiter
      for (int i = 0; i < 10; i++) tx_q.push_back(1'b1);  // EOF + intermission
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; rx_bit = 1'b1; sample_point = 1'b0; error_in = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if (fields !== 120'h0) begin
         n_fail++; $display("FAIL reset_fields: got %h expected 0", fields);
      end
      n_checks++;
      if (error_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_error_out: got %b expected 0", error_out);
      end
      n_checks++;
      if (state_dbg !== IDLE) begin
         n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
      end
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_standard_frame(input string tag);
      logic [58:0] vec;
      vec = 59'b00000100101000001000100000100101000011000001001011111111111;
      err_seen = 1'b0;
      for (int i = 58; i >= 0; i--) send_bit(vec[i]);
      n_checks++;
      if (field_id_a !== 11'h014) begin
         n_fail++; $display("FAIL %s_id_a: got %h expected 014", tag, field_id_a);
      end
      n_checks++;
      if (field_crc !== 15'h2180) begin
         n_fail++; $display("FAIL %s_crc: got %h expected 2180", tag, field_crc);
      end
      n_checks++;
      if (fields !== exp_fields(11'h014, 0, 0, 0, 0, 0, 18'h0, 4'h1, 64'h1, 15'h2180, 1, 0)) begin
         n_fail++;
         $display("FAIL %s_fields: got %h expected %h", tag, fields,
                  exp_fields(11'h014, 0, 0, 0, 0, 0, 18'h0, 4'h1, 64'h1, 15'h2180, 1, 0));
      end
      n_checks++;
      if (err_seen !== 1'b0) begin
         n_fail++; $display("FAIL %s_error_out: got 1 during frame expected 0", tag);
      end
      n_checks++;
      if (state_dbg !== IDLE) begin
         n_fail++; $display("FAIL %s_end_state: got %0d expected %0d", tag, state_dbg, IDLE);
      end
   endtask

   task automatic test_extended_frame();
      build_frame(1'b1, 11'h123, 18'h2ABCD, 1'b0, 4'd2, 64'hBEEF, 15'h1234);
      err_seen = 1'b0;
      send_range(0, tx_q.size());
      n_checks++;
      if (field_data !== 64'hBEEF) begin
         n_fail++; $display("FAIL ext_data: got %h expected beef", field_data);
      end
      n_checks++;
      if (fields !== exp_fields(11'h123, 1, 0, 1, 0, 0, 18'h2ABCD, 4'd2, 64'hBEEF, 15'h1234, 1, 0)) begin
         n_fail++;
         $display("FAIL ext_fields: got %h expected %h", fields,
                  exp_fields(11'h123, 1, 0, 1, 0, 0, 18'h2ABCD, 4'd2, 64'hBEEF, 15'h1234, 1, 0));
      end
      n_checks++;
      if (err_seen !== 1'b0) begin
         n_fail++; $display("FAIL ext_error_out: got 1 during frame expected 0");
      end
   endtask

   task automatic test_remote_frame();
      build_frame(1'b0, 11'h555, 18'h0, 1'b1, 4'd4, 64'hFFFF_FFFF, 15'h0F0F);
      send_range(0, crc_tx_idx);
      n_checks++;
      if (state_dbg !== CRC) begin
         n_fail++; $display("FAIL remote_after_dlc_state: got %0d expected %0d", state_dbg, CRC);
      end
      send_range(crc_tx_idx, tx_q.size());
      n_checks++;
      if (fields !== exp_fields(11'h555, 0, 1, 0, 0, 0, 18'h0, 4'd4, 64'h0, 15'h0F0F, 1, 0)) begin
         n_fail++;
         $display("FAIL remote_fields: got %h expected %h", fields,
                  exp_fields(11'h555, 0, 1, 0, 0, 0, 18'h0, 4'd4, 64'h0, 15'h0F0F, 1, 0));
      end
   endtask

   task automatic test_dlc15_frame();
      build_frame(1'b0, 11'h7F0, 18'h0, 1'b0, 4'hF, 64'h0123_4567_89AB_CDEF, 15'h2AAA);
      err_seen = 1'b0;
      send_range(0, tx_q.size());
      n_checks++;
      if (fields !== exp_fields(11'h7F0, 0, 0, 0, 0, 0, 18'h0, 4'hF, 64'h0123_4567_89AB_CDEF,
                                15'h2AAA, 1, 0)) begin
         n_fail++;
         $display("FAIL dlc15_fields: got %h expected %h", fields,
                  exp_fields(11'h7F0, 0, 0, 0, 0, 0, 18'h0, 4'hF, 64'h0123_4567_89AB_CDEF,
                             15'h2AAA, 1, 0));
      end
      n_checks++;
      if (err_seen !== 1'b0) begin
         n_fail++; $display("FAIL dlc15_error_out: got 1 during frame expected 0");
      end
   endtask

   task automatic test_stuff_error();
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      n_checks++;
      if (err_at_sample !== 1'b0) begin
         n_fail++; $display("FAIL stuff_before_6th: got %b expected 0", err_at_sample);
      end
      send_bit(1'b0);
      n_checks++;
      if (err_at_sample !== 1'b1) begin
         n_fail++; $display("FAIL stuff_error_out: got %b expected 1", err_at_sample);
      end
      n_checks++;
      if (state_dbg !== ERROR) begin
         n_fail++; $display("FAIL stuff_state: got %0d expected %0d", state_dbg, ERROR);
      end
      // A dominant sample restarts the recovery count.
      send_ones(6);
      send_bit(1'b0);
      send_ones(10);
      n_checks++;
      if (error_out !== 1'b1) begin
         n_fail++; $display("FAIL stuff_recover_10: got %b expected 1", error_out);
      end
      send_ones(1);
      n_checks++;
      if (error_out !== 1'b0 || state_dbg !== IDLE) begin
         n_fail++;
         $display("FAIL stuff_recover_11: got err=%b state=%0d expected err=0 state=%0d",
                  error_out, state_dbg, IDLE);
      end
   endtask

   task automatic test_form_error();
      build_frame(1'b0, 11'h3A5, 18'h0, 1'b0, 4'd1, 64'h5A, 15'h1111);
      send_range(0, region_len);
      send_bit(1'b0);
      n_checks++;
      if (err_at_sample !== 1'b1 || state_dbg !== ERROR) begin
         n_fail++;
         $display("FAIL form_crc_delim: got err=%b state=%0d expected err=1 state=%0d",
                  err_at_sample, state_dbg, ERROR);
      end
      send_ones(11);
      n_checks++;
      if (error_out !== 1'b0) begin
         n_fail++; $display("FAIL form_crc_delim_recover: got %b expected 0", error_out);
      end
      send_range(0, region_len + 6);
      n_checks++;
      if (err_at_sample !== 1'b0 || state_dbg !== EOF) begin
         n_fail++;
         $display("FAIL form_eof_pre: got err=%b state=%0d expected err=0 state=%0d",
                  err_at_sample, state_dbg, EOF);
      end
      send_bit(1'b0);
      n_checks++;
      if (err_at_sample !== 1'b1) begin
         n_fail++; $display("FAIL form_eof_bit: got %b expected 1", err_at_sample);
      end
      send_ones(11);
      n_checks++;
      if (error_out !== 1'b0 || state_dbg !== IDLE) begin
         n_fail++;
         $display("FAIL form_eof_recover: got err=%b state=%0d expected err=0 state=%0d",
                  error_out, state_dbg, IDLE);
      end
   endtask

   task automatic test_error_in();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(posedge clock); #1;
      error_in = 1'b1;
      @(posedge clock); #1;
      error_in = 1'b0;
      n_checks++;
      if (state_dbg !== ERROR || error_out !== 1'b0) begin
         n_fail++;
         $display("FAIL error_in_abort: got state=%0d err=%b expected state=%0d err=0",
                  state_dbg, error_out, ERROR);
      end
      n_checks++;
      if (field_id_a !== 11'h002) begin
         n_fail++; $display("FAIL error_in_partial_id: got %h expected 002", field_id_a);
      end
      send_ones(11);
      n_checks++;
      if (state_dbg !== IDLE) begin
         n_fail++; $display("FAIL error_in_recover: got %0d expected %0d", state_dbg, IDLE);
      end
      // Abort and a dominant sample on the same clock: no SOF is taken.
      @(posedge clock); #1;
      rx_bit = 1'b0; sample_point = 1'b1; error_in = 1'b1;
      @(posedge clock); #1;
      sample_point = 1'b0; error_in = 1'b0;
      n_checks++;
      if (state_dbg !== ERROR || field_id_a !== 11'h002 || error_out !== 1'b0) begin
         n_fail++;
         $display("FAIL error_in_vs_sample: got state=%0d id_a=%h err=%b expected state=%0d id_a=002 err=0",
                  state_dbg, field_id_a, error_out, ERROR);
      end
      repeat (4) @(posedge clock);
      #1;
      send_ones(11);
   endtask

   task automatic test_reset_mid_data();
      build_frame(1'b0, 11'h0F0, 18'h0, 1'b0, 4'd2, 64'hA5C3, 15'h0001);
      send_range(0, crc_tx_idx - 8);
      n_checks++;
      if (state_dbg !== DATA) begin
         n_fail++; $display("FAIL mid_data_state: got %0d expected %0d", state_dbg, DATA);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (fields !== 120'h0 || error_out !== 1'b0 || state_dbg !== IDLE) begin
         n_fail++;
         $display("FAIL async_reset: got fields=%h err=%b state=%0d expected 0 0 %0d",
                  fields, error_out, state_dbg, IDLE);
      end
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      test_standard_frame("after_reset");
   endtask

   initial begin
      test_reset();
      test_standard_frame("std");
      test_extended_frame();
      test_remote_frame();
      test_dlc15_frame();
      test_stuff_error();
      test_form_error();
      test_error_in();
      test_reset_mid_data();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
